data_setup_v: RTL
=================

Name: data_setup_v

Overview:
- Systolic-skew stage directly upstream of the 16-column vertical FIFO buffer.
- Accepts a tile of N rows, each row being 16 bytes (one byte per column), from the global-buffer read path through a valid/ready handshake.
- Writes each column's byte stream into that column's FIFO with a diagonal skew: column c receives c leading zeros, then its N data bytes, then (N_COL-1-c) trailing zeros.
- The downstream PE array therefore sees a correct wavefront.

Parameters:
- N_COL, 16, number of columns / FIFOs.
- DW, 8, data byte width.
- CNT_W, 8, width of the row-count and step counters. Maximum N is 2^CNT_W-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- start  input  1  one-cycle tile start. Sampled only in IDLE.
- row_num  input  CNT_W  N, the rows in the tile. Sampled with start.
- in_valid  input  1  upstream row valid.
- in_ready  output  1  row accepted when in_valid && in_ready.
- in_row  input  DW x N_COL (unpacked [N_COL-1:0])  row bytes. Element c goes to column c.
- fifo_WREADY_col  input  1 x N_COL  per-column FIFO ready.
- fifo_WVALID_col  output  1 x N_COL  per-column write valid.
- data_col  output  DW x N_COL  per-column write byte.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse when the tile is fully written.

Behaviour:
- Reset values: all outputs 0; state IDLE; step counter s = 0; delay lines and pending bits cleared.
- State IDLE:
  - start && row_num != 0 → RUN. Latch N, set s = 0, clear all delay-line registers to 0.
  - start && row_num == 0 → pulse done next cycle and stay in IDLE. No writes.
- Per-column pending bit p[c] drives fifo_WVALID_col[c]. p[c] clears on the cycle fifo_WREADY_col[c] is high.
- step_ok = AND over all c of (!p[c] || fifo_WREADY_col[c]). A column still waiting stalls all columns (lockstep).
- State RUN: a step fires when step_ok && (s >= N || in_valid).
  - in_ready = (state == RUN) && s < N && step_ok. It is combinational on fifo_WREADY_col and never depends on in_valid.
  - On each fired step:
    - Delay line c has depth c (total 120 bytes) and shifts by one.
    - Its input is in_row[c] when s < N, else 0.
    - data_col[c] <= delay-line output (column 0 has depth 0, so it takes in_row[0] or 0 directly).
    - All p[c] are set to 1; s increments.
- Timing: row r byte c is presented on data_col[c] with WVALID one cycle after step r+c fires. The minimum row-accept-to-col0-valid latency is 1 cycle.
- Throughput: one step per cycle when every FIFO is ready.
- Step count: each tile takes exactly N+N_COL-1 steps. When the step with s == N+N_COL-2 fires → DRAIN.
- State DRAIN: wait until all p[c] == 0, then pulse done for 1 cycle → IDLE.
- start in RUN or DRAIN is ignored. row_num changes outside IDLE are ignored.
- A FIFO stuck not-ready holds every column's data_col and WVALID stable. A pending column's byte never changes before it is accepted.
- Asynchronous reset mid-tile aborts the tile: all state is cleared and no done is issued.
- Counter arithmetic is unsigned in CNT_W+1 bits, so N+N_COL-1 does not wrap.

Decomposition:
- Shared package (accel_pkg): N_COL, DW, a byte_t typedef, and the state enum {IDLE, RUN, DRAIN}.
- One natural sub-module, skew_delay_line: a parameterized depth-D, DW-wide shift register with a shift enable and a synchronous clear. Instantiate it once per column with D = c in a generate loop.

Test Plan:
- N=1, all FIFOs always ready, row bytes 0x01..0x10:
  - column c gets exactly 16 writes;
  - its only nonzero write is 0x(c+1), at write index c;
  - done asserts 16 cycles after acceptance plus 1.
- N=4, continuous in_valid, all ready:
  - in_ready is high for 4 consecutive cycles;
  - column 15's sequence is 15 zeros then rows 0..3 byte 15 (19 writes);
  - column 0's sequence is the 4 data bytes then 15 zeros.
- N=3, fifo_WREADY_col[7] low for 5 cycles mid-tile:
  - all columns freeze data and WVALID;
  - in_ready is low;
  - the per-column sequences are identical to the unstalled run.
- N=8, in_valid deasserted for 3 cycles after row 2:
  - no step fires and no new WVALID rises during the gap;
  - output order is preserved.
- start with row_num=0:
  - done pulses 1 cycle later;
  - zero WVALIDs and busy stays low.
- Reset asserted during step 10 of an N=20 tile:
  - all outputs are 0 immediately;
  - no done is issued;
  - a following start with N=2 produces a correct skewed output.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared constants and types for the systolic data-setup path feeding the column FIFOs.
package accel_pkg;

   localparam int N_COL = 16;
   localparam int DW    = 8;
   localparam int CNT_W = 8;

   typedef logic [DW-1:0] byte_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Depth-D byte shift register; depth 0 degenerates to a wire so column 0 has no skew.
module skew_delay_line #(
   parameter int D  = 1,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   generate
      if (D == 0) begin : g_wire
         logic unused_ctl;
         assign unused_ctl = ^{clk, rst, clr, en};
         assign dout       = din;
      end else begin : g_shift
         logic [DW-1:0] taps [D];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               taps <= '{default: '0};
            end else if (clr) begin
               taps <= '{default: '0};
            end else if (en) begin
               taps[0] <= din;
               for (int i = 1; i < D; i++) begin
                  taps[i] <= taps[i-1];
               end
            end
         end

         assign dout = taps[D-1];
      end
   endgenerate

endmodule

// File: rtl/data_setup_v.sv
// Diagonal-skew writer: spreads each tile row across the column FIFOs so the PE array sees a wavefront.
//   state | meaning
//   IDLE  | waiting for start; row_num == 0 answers with an immediate done
//   RUN   | firing steps s = 0 .. N+N_COL-2, all columns in lockstep
//   DRAIN | last step issued, waiting for every column write to be accepted
module data_setup_v #(
   parameter int N_COL = accel_pkg::N_COL,
   parameter int DW    = accel_pkg::DW,
   parameter int CNT_W = accel_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] row_num,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_row [N_COL-1:0],
   input  logic [N_COL-1:0] fifo_WREADY_col,
   output logic [N_COL-1:0] fifo_WVALID_col,
   output logic [DW-1:0]    data_col [N_COL-1:0],
   output logic             busy,
   output logic             done
);

   import accel_pkg::*;

   state_t           state;
   logic [CNT_W:0]   s;
   logic [CNT_W:0]   n_lat;
   logic [N_COL-1:0] pend;
   logic             step_ok;
   logic             s_lt_n;
   logic             fire;
   logic             last_step;
   logic             tile_go;
   logic [DW-1:0]    line_in  [N_COL-1:0];
   logic [DW-1:0]    line_out [N_COL-1:0];

   // One stuck column blocks every column so the wavefront never tears.
   assign step_ok   = &(~pend | fifo_WREADY_col);
   assign s_lt_n    = s < n_lat;
   assign in_ready  = (state == RUN) && s_lt_n && step_ok;
   assign fire      = (state == RUN) && step_ok && (!s_lt_n || in_valid);
   assign last_step = s == (n_lat + (CNT_W+1)'(N_COL - 2));
   assign tile_go   = (state == IDLE) && start && (row_num != '0);

   assign busy            = (state == RUN) || (state == DRAIN);
   assign fifo_WVALID_col = pend;

   generate
      for (genvar c = 0; c < N_COL; c++) begin : g_col
         assign line_in[c] = s_lt_n ? in_row[c] : '0;

         skew_delay_line #(
            .D  (c),
            .DW (DW)
         ) u_line (
            .clk  (clk),
            .rst  (rst),
            .clr  (tile_go),
            .en   (fire),
            .din  (line_in[c]),
            .dout (line_out[c])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         s     <= '0;
         n_lat <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (row_num != '0) begin
                     state <= RUN;
                     n_lat <= {1'b0, row_num};
                     s     <= '0;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (fire) begin
                  s <= s + 1'b1;
                  if (last_step) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pend == '0) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A pending byte is only replaced by the next step, which cannot fire until it is taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend     <= '0;
         data_col <= '{default: '0};
      end else if (fire) begin
         pend     <= '1;
         data_col <= line_out;
      end else begin
         pend <= pend & ~fifo_WREADY_col;
      end
   end

endmodule
